// File: rtl/ram_sdp_reader_if.sv
// Bundle of the command, RAM read-port and stream signals around ram_sdp_reader.
// master is the reader's own view; slave is the surrounding logic (RAM, command source, sink).
interface ram_sdp_reader_if #(
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned LEN_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  enb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] doutb;
    logic                  doutb_valid;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, doutb, doutb_valid, m_ready,
        output cmd_ready, enb, addrb, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, doutb, doutb_valid, m_ready,
        input  cmd_ready, enb, addrb, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/ram_sdp_reader.sv
// Burst read controller for a simple dual-port RAM read port: credit-limited issue
// into a small return FIFO that absorbs the RAM latency, drained as a valid/ready stream.
module ram_sdp_reader #(
    parameter int unsigned DATA_WIDTH       = 36,
    parameter int unsigned ADDR_WIDTH       = 14,
    parameter int unsigned RAM_DEPTH        = 1024,
    parameter int unsigned DOUT_PIPE_NUMBER = 1,
    parameter int unsigned LEN_WIDTH        = 16,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic             clk,
    input  logic             rst,
    ram_sdp_reader_if.master bus
);
    localparam int unsigned L  = DOUT_PIPE_NUMBER + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned FW = $clog2(L + 1);

    typedef enum logic [1:0] {FLUSH, IDLE, ISSUE, DRAIN} state_t;

    state_t                state_q;
    logic [FW-1:0]         flush_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [LEN_WIDTH-1:0]  last_idx_q;
    logic [LEN_WIDTH-1:0]  pop_cnt_q;
    logic [CW-1:0]         out_q, out_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  busy_q;
    logic                  done_q;

    logic credit_ok, enb, push, m_valid, pop, m_last;

    // Credit: reads in flight plus words already held must leave a free FIFO slot.
    assign credit_ok = ({1'b0, out_q} + {1'b0, cnt_q}) < (CW + 1)'(FIFO_DEPTH);
    assign enb       = (state_q == ISSUE) && credit_ok;
    assign push      = bus.doutb_valid && (out_q != '0);
    assign m_valid   = (cnt_q != '0);
    assign pop       = m_valid && bus.m_ready;
    assign m_last    = m_valid && (pop_cnt_q == last_idx_q);

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.enb       = enb;
    assign bus.addrb     = addr_q;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = mem_q[rd_ptr_q];
    assign bus.m_last    = m_last;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

    always_comb begin
        out_d = out_q;
        if (enb && !push)      out_d = out_q + CW'(1);
        else if (!enb && push) out_d = out_q - CW'(1);

        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);

        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q;
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

        addr_d = (addr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FLUSH;
            flush_q     <= '0;
            addr_q      <= '0;
            remaining_q <= '0;
            last_idx_q  <= '0;
            pop_cnt_q   <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= 1'b0;
            if (push) mem_q[wr_ptr_q] <= bus.doutb;
            if (pop)  pop_cnt_q <= pop_cnt_q + LEN_WIDTH'(1);

            case (state_q)
                FLUSH: begin
                    if (flush_q == FW'(L - 1)) state_q <= IDLE;
                    else                       flush_q <= flush_q + FW'(1);
                end
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q      <= bus.cmd_addr;
                            remaining_q <= bus.cmd_len;
                            last_idx_q  <= bus.cmd_len - LEN_WIDTH'(1);
                            pop_cnt_q   <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (enb) begin
                        addr_q      <= addr_d;
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                        if (remaining_q == LEN_WIDTH'(1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Popping the last word implies nothing is in flight and the FIFO empties now.
                    if (pop && m_last) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= FLUSH;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_sdp_reader.sv
// Scoreboard bench for ram_sdp_reader: stimulus queues expected addresses and beats,
// a negedge monitor pops and compares them as the DUT issues reads and streams data.
module tb_ram_sdp_reader;
    localparam int unsigned DW = 36;
    localparam int unsigned AW = 14;
    localparam int unsigned LW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_sdp_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    ram_sdp_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(1024),
        .DOUT_PIPE_NUMBER(1), .LEN_WIDTH(LW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // RAM read port model with a two-cycle read latency; it is not reset.
    logic [DW-1:0] ram [1024];
    logic          v1 = 1'b0, v2 = 1'b0;
    logic [DW-1:0] d1 = '0, d2 = '0;
    always @(posedge clk) begin
        v1 <= bus.enb;
        d1 <= ram[bus.addrb[9:0]];
        v2 <= v1;
        d2 <= d1;
    end
    assign bus.doutb_valid = v2;
    assign bus.doutb       = d2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    logic [AW-1:0] exp_addr[$];

    int burst_id = 0, mon_id = 0;
    int enb_n, enb_first, enb_lastc, beats, first_hs, last_hs, first_mv, max_sum;
    int done_cnt = 0, done_cyc = 0, hs_cyc = 0;
    int tb_out = 0, tb_occ = 0;
    bit mv_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        beat_t e;
        bit hs, rv;
        forever begin
            @(negedge clk);
            if (mon_id != burst_id) begin
                mon_id = burst_id; enb_n = 0; beats = 0; mv_seen = 0; max_sum = 0;
            end
            if (rst) begin
                exp_q.delete(); exp_addr.delete(); tb_out = 0; tb_occ = 0;
            end else begin
                if (tb_out + tb_occ > max_sum) max_sum = tb_out + tb_occ;
                if (bus.enb) begin
                    if (enb_n == 0) enb_first = cyc;
                    enb_lastc = cyc;
                    enb_n++;
                    if (exp_addr.size() == 0) chk("unexpected_enb", 64'(bus.addrb), 64'hFFFF);
                    else chk("addrb", 64'(bus.addrb), 64'(exp_addr.pop_front()));
                end
                if (bus.m_valid && !mv_seen) begin
                    mv_seen = 1; first_mv = cyc;
                end
                hs = bus.m_valid && bus.m_ready;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(bus.m_data), 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", 64'(bus.m_data), 64'(e.data));
                        chk("m_last", 64'(bus.m_last), 64'(e.last));
                    end
                    if (beats == 0) first_hs = cyc;
                    last_hs = cyc;
                    beats++;
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("busy_at_done", 64'(bus.busy), 64'd0);
                end
                rv = bus.doutb_valid && (tb_out > 0);
                tb_out = tb_out + (bus.enb ? 1 : 0) - (rv ? 1 : 0);
                tb_occ = tb_occ + (rv ? 1 : 0) - (hs ? 1 : 0);
            end
        end
    end

    task automatic push_beats(input int addr, input int len);
        int a;
        for (int i = 0; i < len; i++) begin
            a = (addr + i) % 1024;
            exp_addr.push_back(AW'(a));
            exp_q.push_back('{36'hC_0000_0000 + DW'(a), i == len - 1});
        end
    endtask

    task automatic send_cmd(input int addr, input int len);
        burst_id++;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = LW'(len);
        for (int i = 0; i < 50 && !bus.cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!bus.cmd_ready) chk("cmd_ready_timeout", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk); #1;
        hs_cyc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) begin
            @(posedge clk); #1;
        end
        if (done_cnt == d0) chk("done_timeout", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic check_flush();
        @(negedge clk); chk("flush_ready_c0", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk); chk("flush_ready_c1", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk); chk("flush_ready_c2", 64'(bus.cmd_ready), 64'd1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        for (int i = 0; i < 1024; i++) ram[i] = 36'hC_0000_0000 + DW'(i);
        ram[10] = 36'hA0; ram[11] = 36'hA1; ram[12] = 36'hA2; ram[13] = 36'hA3;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.m_ready   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_enb",       64'(bus.enb),       64'd0);
        chk("rst_addrb",     64'(bus.addrb),     64'd0);
        chk("rst_m_valid",   64'(bus.m_valid),   64'd0);
        chk("rst_m_data",    64'(bus.m_data),    64'd0);
        chk("rst_m_last",    64'(bus.m_last),    64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_done",      64'(bus.done),      64'd0);
        @(posedge clk); #1 rst = 1'b0;
        check_flush();
        bus.m_ready = 1'b1;

        // Basic burst with latency and done timing
        exp_addr.push_back(AW'(10)); exp_addr.push_back(AW'(11));
        exp_addr.push_back(AW'(12)); exp_addr.push_back(AW'(13));
        exp_q.push_back('{36'hA0, 1'b0}); exp_q.push_back('{36'hA1, 1'b0});
        exp_q.push_back('{36'hA2, 1'b0}); exp_q.push_back('{36'hA3, 1'b1});
        send_cmd(10, 4);
        wait_done(40);
        chk("t1_first_enb",    64'(enb_first - hs_cyc), 64'd0);
        chk("t1_first_mvalid", 64'(first_mv - hs_cyc),  64'd3);
        chk("t1_beats",        64'(beats),              64'd4);
        chk("t1_beat_span",    64'(last_hs - first_hs), 64'd3);
        chk("t1_done_cycle",   64'(done_cyc - last_hs), 64'd1);

        // Address wrap
        exp_addr.push_back(AW'(1022)); exp_addr.push_back(AW'(1023));
        exp_addr.push_back(AW'(0));    exp_addr.push_back(AW'(1));
        exp_q.push_back('{36'hC_0000_03FE, 1'b0}); exp_q.push_back('{36'hC_0000_03FF, 1'b0});
        exp_q.push_back('{36'hC_0000_0000, 1'b0}); exp_q.push_back('{36'hC_0000_0001, 1'b1});
        send_cmd(1022, 4);
        wait_done(40);
        chk("t2_beats", 64'(beats), 64'd4);

        // Backpressure after three beats
        push_beats(300, 16);
        send_cmd(300, 16);
        for (int i = 0; i < 50 && beats < 3; i++) begin
            @(posedge clk); #1;
        end
        bus.m_ready = 1'b0;
        chk("t3_stall_start", 64'(beats), 64'd3);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_enb_under_stall", 64'(enb_n), 64'd7);
        bus.m_ready = 1'b1;
        wait_done(100);
        chk("t3_beats",   64'(beats),   64'd16);
        chk("t3_max_sum", 64'(max_sum), 64'd4);

        // Zero length
        send_cmd(5, 0);
        @(negedge clk);
        chk("t4_done_pulse", 64'(bus.done), 64'd1);
        chk("t4_busy",       64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("t4_done_once",  64'(bus.done), 64'd0);
        repeat (5) @(negedge clk);
        chk("t4_no_enb",     64'(enb_n),    64'd0);
        chk("t4_no_mvalid",  64'(mv_seen),  64'd0);

        // Reset with two reads outstanding
        push_beats(100, 8);
        send_cmd(100, 8);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("t5_rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("t5_rst_enb",       64'(bus.enb),       64'd0);
        chk("t5_rst_m_valid",   64'(bus.m_valid),   64'd0);
        chk("t5_rst_busy",      64'(bus.busy),      64'd0);
        @(posedge clk); #1 rst = 1'b0;
        check_flush();
        exp_addr.push_back(AW'(0)); exp_addr.push_back(AW'(1));
        exp_q.push_back('{36'hC_0000_0000, 1'b0}); exp_q.push_back('{36'hC_0000_0001, 1'b1});
        send_cmd(0, 2);
        wait_done(40);
        chk("t5_beats", 64'(beats), 64'd2);

        // Full-rate burst
        push_beats(500, 64);
        send_cmd(500, 64);
        wait_done(200);
        chk("t6_enb_count", 64'(enb_n),                64'd64);
        chk("t6_enb_span",  64'(enb_lastc - enb_first), 64'd63);
        chk("t6_beats",     64'(beats),                64'd64);
        chk("t6_beat_span", 64'(last_hs - first_hs),   64'd63);

        repeat (5) @(posedge clk);
        #1;
        chk("leftover_beats", 64'(exp_q.size()),    64'd0);
        chk("leftover_addrs", 64'(exp_addr.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
